// File: rtl/ddr_sdram_responder.sv
// ddr_sdram_responder
//   Device-side model of an MT46H32M16LF command interface. It decodes the
//   RAS/CAS/WE command pins, holds the mode register and the open row of each
//   bank, and stores write bursts in a reduced array indexed {BA, row, col}.
//   Read bursts come back after the programmed CAS latency, with a DQS strobe.
//   One data word moves on each rising edge.
// Ports
//   DDR_CLK, RST          clock; asynchronous active-high reset
//   CKE, RAS, CAS, WE     command pins (command pins are active low)
//   BA, ADDR              bank and row/column/mode value; ADDR[10] = precharge all
//   DM, DQ_IN             write byte mask (1 = keep stored byte) and write data
//   DQ_OUT, DQ_OE         read data and read-data drive enable
//   DQS_OUT, DQS_OE       read strobe and strobe drive enable
//   MODE_VALID            a LOAD MODE has been seen since reset
//   ERR                   sticky errors: [0] closed bank, [1] double ACTIVE,
//                         [2] READ/WRITE while busy, [3] READ/WRITE before LOAD MODE
module ddr_sdram_responder #(
  parameter int ROW_AW = 4,
  parameter int COL_AW = 4
) (
  input  logic        DDR_CLK,
  input  logic        RST,
  input  logic        CKE,
  input  logic        RAS,
  input  logic        CAS,
  input  logic        WE,
  input  logic [1:0]  BA,
  input  logic [12:0] ADDR,
  input  logic [1:0]  DM,
  input  logic [15:0] DQ_IN,
  output logic [15:0] DQ_OUT,
  output logic        DQ_OE,
  output logic        DQS_OUT,
  output logic        DQS_OE,
  output logic        MODE_VALID,
  output logic [3:0]  ERR
);
  localparam int MEM_AW = 2 + ROW_AW + COL_AW;

  typedef enum logic [1:0] {IDLE, RD_LAT, RD_BURST, WR_BURST} state_e;

  state_e state_q, state_d;

  // mode register: burst length kept as BL-1 (0,1,3,7), CAS latency 2 or 3
  logic                   mode_valid_q;
  logic [2:0]             blm1_q;
  logic [1:0]             cl_q;
  logic [3:0]             err_q;
  logic [3:0]             open_q;
  logic [3:0][ROW_AW-1:0] row_q;

  // burst context, latched when the READ/WRITE is accepted
  logic [1:0]        bst_bank_q;
  logic [ROW_AW-1:0] bst_row_q;
  logic [COL_AW-1:0] bst_col_q;
  logic [2:0]        bst_blm1_q;
  logic [2:0]        idx_q;
  logic [1:0]        lat_q;

  logic [15:0] dq_q, dq_d;
  logic        dq_oe_q, dq_oe_d, dqs_q, dqs_d, dqs_oe_q, dqs_oe_d;

  // ---------------- command decode ----------------
  logic [2:0] rcw;
  logic       cmd_lmr, cmd_act, cmd_pre, cmd_rd, cmd_wr, busy, go_rd, go_wr;

  assign rcw     = {RAS, CAS, WE};
  assign cmd_lmr = CKE && (rcw == 3'b000);
  assign cmd_act = CKE && (rcw == 3'b010);
  assign cmd_pre = CKE && (rcw == 3'b001);
  assign cmd_rd  = CKE && (rcw == 3'b101);
  assign cmd_wr  = CKE && (rcw == 3'b100);
  assign busy    = (state_q != IDLE);
  assign go_rd   = cmd_rd && !busy && open_q[BA];
  assign go_wr   = cmd_wr && !busy && open_q[BA];

  // Not every ADDR bit is meaningful for every command or parameter set.
  logic unused_addr;
  assign unused_addr = ^ADDR;

  // ---------------- burst addressing ----------------
  // Sequential burst wrapping inside the BL-aligned block: upper column bits
  // stay fixed, the low log2(BL) bits count modulo BL from the start column.
  logic [COL_AW-1:0] bl_mask, col_i;
  logic [MEM_AW-1:0] mem_addr;

  assign bl_mask  = COL_AW'(bst_blm1_q);
  assign col_i    = (bst_col_q & ~bl_mask) | ((bst_col_q + COL_AW'(idx_q)) & bl_mask);
  assign mem_addr = {bst_bank_q, bst_row_q, col_i};

  logic [15:0] mem [2**MEM_AW];

  // Storage is deliberately not reset; a reset mid-write keeps the words
  // already captured.
  always_ff @(posedge DDR_CLK) begin
    if (state_q == WR_BURST) begin
      if (!DM[0]) mem[mem_addr][7:0]  <= DQ_IN[7:0];
      if (!DM[1]) mem[mem_addr][15:8] <= DQ_IN[15:8];
    end
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge DDR_CLK or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (go_rd)      state_d = RD_LAT;
        else if (go_wr) state_d = WR_BURST;
      end
      // leaves on the edge that raises the preamble (T+CL-1)
      RD_LAT:   if (lat_q == 2'd1) state_d = RD_BURST;
      RD_BURST: if (idx_q == bst_blm1_q) state_d = IDLE;
      WR_BURST: if (idx_q == bst_blm1_q) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs (registered pin drivers) ----------------
  always_comb begin
    dq_d     = '0;
    dq_oe_d  = 1'b0;
    dqs_d    = 1'b0;
    dqs_oe_d = 1'b0;
    case (state_q)
      RD_LAT: begin
        // preamble: strobe driven low one cycle ahead of the first word
        if (lat_q == 2'd1) dqs_oe_d = 1'b1;
      end
      RD_BURST: begin
        dq_d     = mem[mem_addr];
        dq_oe_d  = 1'b1;
        dqs_oe_d = 1'b1;
        dqs_d    = ~idx_q[0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge DDR_CLK or posedge RST) begin
    if (RST) begin
      dq_q     <= '0;
      dq_oe_q  <= 1'b0;
      dqs_q    <= 1'b0;
      dqs_oe_q <= 1'b0;
    end else begin
      dq_q     <= dq_d;
      dq_oe_q  <= dq_oe_d;
      dqs_q    <= dqs_d;
      dqs_oe_q <= dqs_oe_d;
    end
  end

  // ---------------- mode, bank and burst context ----------------
  always_ff @(posedge DDR_CLK or posedge RST) begin
    if (RST) begin
      mode_valid_q <= 1'b0;
      blm1_q       <= 3'd1;
      cl_q         <= 2'd3;
      err_q        <= '0;
      open_q       <= '0;
      row_q        <= '0;
      bst_bank_q   <= '0;
      bst_row_q    <= '0;
      bst_col_q    <= '0;
      bst_blm1_q   <= '0;
      idx_q        <= '0;
      lat_q        <= '0;
    end else begin
      if (cmd_lmr) begin
        mode_valid_q <= 1'b1;
        // codes 1xx are reserved and leave BL unchanged
        if (!ADDR[2]) blm1_q <= 3'((4'd1 << ADDR[1:0]) - 4'd1);
        cl_q <= (ADDR[6:4] == 3'd2) ? 2'd2 : 2'd3;
      end
      if (cmd_act) begin
        if (open_q[BA]) err_q[1] <= 1'b1;
        open_q[BA] <= 1'b1;
        row_q[BA]  <= ADDR[ROW_AW-1:0];
      end
      if (cmd_pre) begin
        if (ADDR[10]) open_q     <= '0;
        else          open_q[BA] <= 1'b0;
      end
      if (cmd_rd || cmd_wr) begin
        if (!open_q[BA]) err_q[0] <= 1'b1;
        if (busy)        err_q[2] <= 1'b1;
      end
      // Without a LOAD MODE the registers still hold BL=2, CL=3 from reset.
      if (go_rd || go_wr) begin
        if (!mode_valid_q) err_q[3] <= 1'b1;
        bst_bank_q <= BA;
        bst_row_q  <= row_q[BA];
        bst_col_q  <= ADDR[COL_AW-1:0];
        bst_blm1_q <= blm1_q;
        idx_q      <= '0;
        lat_q      <= cl_q - 2'd1;
      end else if (state_q == RD_LAT) begin
        lat_q <= lat_q - 2'd1;
      end else if (state_q == RD_BURST || state_q == WR_BURST) begin
        idx_q <= idx_q + 3'd1;
      end
    end
  end

  assign DQ_OUT     = dq_q;
  assign DQ_OE      = dq_oe_q;
  assign DQS_OUT    = dqs_q;
  assign DQS_OE     = dqs_oe_q;
  assign MODE_VALID = mode_valid_q;
  assign ERR        = err_q;

endmodule

// File: tb/tb_ddr_sdram_responder.sv
// Directed bench for ddr_sdram_responder: mode load, write/read timing,
// burst wrap, byte masking, closed-bank and busy errors, async reset.
module tb_ddr_sdram_responder;
  logic        DDR_CLK = 1'b0;
  logic        RST = 1'b1;
  logic        CKE = 1'b1;
  logic        RAS = 1'b1, CAS = 1'b1, WE = 1'b1;
  logic [1:0]  BA = '0;
  logic [12:0] ADDR = '0;
  logic [1:0]  DM = '0;
  logic [15:0] DQ_IN = '0;
  logic [15:0] DQ_OUT;
  logic        DQ_OE, DQS_OUT, DQS_OE, MODE_VALID;
  logic [3:0]  ERR;

  localparam logic [2:0] C_LMR = 3'b000, C_ACT = 3'b010, C_PRE = 3'b001,
                         C_RD  = 3'b101, C_WR  = 3'b100, C_NOP = 3'b111;

  int n_vec = 0;
  int n_err = 0;

  ddr_sdram_responder #(.ROW_AW(4), .COL_AW(4)) dut (
    .DDR_CLK(DDR_CLK), .RST(RST), .CKE(CKE), .RAS(RAS), .CAS(CAS), .WE(WE),
    .BA(BA), .ADDR(ADDR), .DM(DM), .DQ_IN(DQ_IN),
    .DQ_OUT(DQ_OUT), .DQ_OE(DQ_OE), .DQS_OUT(DQS_OUT), .DQS_OE(DQS_OE),
    .MODE_VALID(MODE_VALID), .ERR(ERR)
  );

  always #5 DDR_CLK = ~DDR_CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // drive one cycle at the falling edge; return 1ns after the sampling edge
  task automatic cyc(input logic [2:0] c, input logic [1:0] ba, input logic [12:0] a,
                     input logic [15:0] dq, input logic [1:0] dm);
    @(negedge DDR_CLK);
    {RAS, CAS, WE} = c;
    BA = ba; ADDR = a; DQ_IN = dq; DM = dm;
    @(posedge DDR_CLK);
    #1;
  endtask

  task automatic nop();
    cyc(C_NOP, 2'd0, 13'd0, 16'd0, 2'd0);
  endtask

  task automatic do_reset();
    @(negedge DDR_CLK);
    {RAS, CAS, WE} = C_NOP;
    RST = 1'b1;
    @(negedge DDR_CLK);
    RST = 1'b0;
  endtask

  // words packed low-first: d[15:0] is word 0
  task automatic wr(input logic [1:0] ba, input logic [12:0] col, input int n,
                    input logic [63:0] d, input logic [1:0] dm);
    cyc(C_WR, ba, col, 16'd0, 2'd0);
    for (int i = 0; i < n; i++) cyc(C_NOP, 2'd0, 13'd0, d[16*i +: 16], dm);
  endtask

  task automatic rd(input string tag, input logic [1:0] ba, input logic [12:0] col,
                    input int cl, input int n, input logic [63:0] ex);
    cyc(C_RD, ba, col, 16'd0, 2'd0);
    for (int k = 1; k <= cl + n; k++) begin
      nop();
      if (k < cl - 1) begin
        chk({tag, " lat dqs_oe"}, DQS_OE, 1'b0);
        chk({tag, " lat dq_oe"}, DQ_OE, 1'b0);
      end else if (k == cl - 1) begin
        chk({tag, " pre dqs_oe"}, DQS_OE, 1'b1);
        chk({tag, " pre dqs"}, DQS_OUT, 1'b0);
        chk({tag, " pre dq_oe"}, DQ_OE, 1'b0);
      end else if (k < cl + n) begin
        chk({tag, " dq"}, DQ_OUT, ex[16*(k-cl) +: 16]);
        chk({tag, " dq_oe"}, DQ_OE, 1'b1);
        chk({tag, " dqs"}, DQS_OUT, ((k - cl) % 2) == 0);
      end else begin
        chk({tag, " end dq_oe"}, DQ_OE, 1'b0);
        chk({tag, " end dqs_oe"}, DQS_OE, 1'b0);
        chk({tag, " end dq"}, DQ_OUT, 16'h0);
      end
    end
  endtask

  task automatic rd_closed(input string tag, input logic [1:0] ba);
    logic seen;
    seen = 1'b0;
    cyc(C_RD, ba, 13'd4, 16'd0, 2'd0);
    for (int k = 0; k < 6; k++) begin
      nop();
      seen = seen | DQ_OE;
    end
    chk({tag, " dq_oe never"}, seen, 1'b0);
    chk({tag, " err0"}, ERR[0], 1'b1);
  endtask

  initial begin
    // reset state
    #3;
    chk("rst dq", DQ_OUT, 16'h0);
    chk("rst dq_oe", DQ_OE, 1'b0);
    chk("rst dqs", DQS_OUT, 1'b0);
    chk("rst dqs_oe", DQS_OE, 1'b0);
    chk("rst mode_valid", MODE_VALID, 1'b0);
    chk("rst err", ERR, 4'h0);
    @(negedge DDR_CLK);
    RST = 1'b0;

    // before LOAD MODE: defaults BL=2, CL=3 and ERR[3]
    cyc(C_ACT, 2'd0, 13'd0, 16'd0, 2'd0);
    wr(2'd0, 13'd0, 2, 64'h0000_0000_2222_1111, 2'b00);
    chk("nomode err3", ERR[3], 1'b1);
    rd("nomode rd", 2'd0, 13'd0, 3, 2, 64'h0000_0000_2222_1111);
    chk("nomode err0 clear", ERR[0], 1'b0);
    cyc(C_ACT, 2'd0, 13'd0, 16'd0, 2'd0);
    chk("double act err1", ERR[1], 1'b1);

    // mode 0x021: BL=2, CL=2
    do_reset();
    chk("re-rst err", ERR, 4'h0);
    cyc(C_LMR, 2'd0, 13'h021, 16'd0, 2'd0);
    chk("lmr mode_valid", MODE_VALID, 1'b1);
    cyc(C_ACT, 2'd1, 13'd3, 16'd0, 2'd0);
    wr(2'd1, 13'd4, 2, 64'h0000_0000_5A5A_A5A5, 2'b00);
    rd("bl2cl2", 2'd1, 13'd4, 2, 2, 64'h0000_0000_5A5A_A5A5);

    // burst wrap, BL=4
    cyc(C_LMR, 2'd0, 13'h022, 16'd0, 2'd0);
    wr(2'd1, 13'd4, 4, 64'h0004_0003_0002_0001, 2'b00);
    rd("wrap", 2'd1, 13'd6, 2, 4, 64'h0002_0001_0004_0003);

    // byte mask, BL=1
    cyc(C_LMR, 2'd0, 13'h020, 16'd0, 2'd0);
    wr(2'd1, 13'd8, 1, 64'hFFFF, 2'b00);
    wr(2'd1, 13'd8, 1, 64'h1234, 2'b10);
    rd("mask", 2'd1, 13'd8, 2, 1, 64'hFF34);

    // busy collision: CL=3, BL=2; WRITE one cycle after READ is dropped
    cyc(C_LMR, 2'd0, 13'h031, 16'd0, 2'd0);
    chk("pre-coll err2", ERR[2], 1'b0);
    cyc(C_RD, 2'd1, 13'd4, 16'd0, 2'd0);
    cyc(C_WR, 2'd1, 13'd4, 16'hDEAD, 2'd0);
    cyc(C_NOP, 2'd0, 13'd0, 16'hDEAD, 2'd0);
    cyc(C_NOP, 2'd0, 13'd0, 16'hDEAD, 2'd0);
    chk("coll word0", DQ_OUT, 16'h0001);
    nop();
    chk("coll word1", DQ_OUT, 16'h0002);
    nop();
    chk("coll end dq_oe", DQ_OE, 1'b0);
    chk("coll err2", ERR[2], 1'b1);
    rd("coll reread", 2'd1, 13'd4, 3, 2, 64'h0000_0000_0002_0001);

    // closed bank
    chk("pre-closed err0", ERR[0], 1'b0);
    rd_closed("bank2 closed", 2'd2);

    do_reset();
    cyc(C_LMR, 2'd0, 13'h021, 16'd0, 2'd0);
    cyc(C_ACT, 2'd1, 13'd3, 16'd0, 2'd0);
    cyc(C_PRE, 2'd0, 13'h400, 16'd0, 2'd0);
    chk("pre-all err0", ERR[0], 1'b0);
    rd_closed("pre-all bank1", 2'd1);

    // asynchronous reset mid-burst
    do_reset();
    cyc(C_LMR, 2'd0, 13'h021, 16'd0, 2'd0);
    cyc(C_ACT, 2'd1, 13'd3, 16'd0, 2'd0);
    cyc(C_ACT, 2'd1, 13'd3, 16'd0, 2'd0);
    cyc(C_RD, 2'd1, 13'd4, 16'd0, 2'd0);
    nop();
    nop();
    chk("mid dq_oe", DQ_OE, 1'b1);
    chk("mid err", ERR, 4'h2);
    #2;
    RST = 1'b1;
    #1;
    chk("async dq_oe", DQ_OE, 1'b0);
    chk("async dqs_oe", DQS_OE, 1'b0);
    chk("async err", ERR, 4'h0);
    chk("async mode_valid", MODE_VALID, 1'b0);
    @(negedge DDR_CLK);
    RST = 1'b0;
    rd_closed("post-rst", 2'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ddr_sdram_responder.md
# ddr_sdram_responder

Synthesizable device-side responder for the MT46H32M16LF command interface driven by the team's DDR SDRAM controller. It decodes RAS/CAS/WE/BA/ADDR commands and holds the mode register and per-bank open-row state. It stores write bursts in a reduced internal array and returns read bursts after the programmed CAS latency with a DQS strobe. It is the bench-side and emulation memory that sits on the controller's pin bus. One data word moves per rising edge.

## Interface
Parameters:
- ROW_AW, 4, row address bits kept in storage (ADDR[ROW_AW-1:0])
- COL_AW, 4, column address bits kept in storage (ADDR[COL_AW-1:0]); must be ≥3
- Storage depth is 4·2^ROW_AW·2^COL_AW words of 16 bits, indexed {BA, row, col}.

Ports:
- DDR_CLK  in  1  sole clock; all logic is on the rising edge
- RST  in  1  reset; asynchronous and active-high
- CKE  in  1  clock enable; when low, the cycle is a NOP
- RAS, CAS, WE  in  1 each  active-low command pins
- BA  in  2  bank address
- ADDR  in  13  row, column, or mode value; ADDR[10] is the all-banks precharge flag
- DM  in  2  write byte mask; DM[1] masks the high byte, DM[0] the low byte
- DQ_IN  in  16  write data
- DQ_OUT  out  16  read data
- DQ_OE  out  1  read data valid/drive enable
- DQS_OUT  out  1  read strobe
- DQS_OE  out  1  strobe drive enable
- MODE_VALID  out  1  a mode register load has been seen
- ERR  out  4  sticky protocol error flags

## Operation
- Command decode applies only when CKE=1. {RAS,CAS,WE}:
  - 000 LOAD MODE
  - 010 ACTIVE
  - 001 PRECHARGE
  - 101 READ
  - 100 WRITE
  - all others NOP
- LOAD MODE:
  - ADDR[2:0] sets the burst length: 000→1, 001→2, 010→4, 011→8; any other code keeps the previous BL.
  - ADDR[6:4] sets CL: 2 or 3 are accepted; any other code sets CL=3.
  - MODE_VALID is set.
- ACTIVE opens bank BA with row ADDR. If that bank is already open, ERR[1] is set and the row is replaced.
- PRECHARGE closes bank BA. If ADDR[10]=1, it closes all four banks. Precharging a closed bank is legal.
- READ/WRITE:
  - The bank must be open. If it is not, ERR[0] is set and the command is dropped.
  - If MODE_VALID=0, ERR[3] is set and the command executes with the reset defaults BL=2, CL=3.
- Burst addressing is sequential and wraps within the BL-aligned block: word i uses col = {ADDR[COL_AW-1:log2BL], (ADDR[log2BL-1:0]+i) mod BL}.
- The row and bank are latched at the command. A later PRECHARGE or ACTIVE does not affect an in-flight burst.
- Busy window:
  - For a read: from the command until the last word is driven.
  - For a write: from the command until the last word is captured.
  - A READ or WRITE that arrives while busy is dropped and sets ERR[2]. ACTIVE, PRECHARGE and LOAD MODE are always accepted. LOAD MODE while busy does not alter the in-flight burst.
- Write masking: a byte with DM high keeps its stored value.
- States: IDLE, RD_LAT (counts CL-1), RD_BURST (BL words), WR_BURST (BL words).
- ERR bits clear only on RST.

## Timing
- Reset values:
  - DQ_OUT=0, DQ_OE=0, DQS_OUT=0, DQS_OE=0, MODE_VALID=0, ERR=0
  - all banks closed; BL=2, CL=3; state IDLE
  - storage contents are not reset
- Any command is sampled at rising edge T.
- WRITE: word i is sampled from DQ_IN/DM at edge T+1+i, for i=0..BL-1. The earliest next READ/WRITE is accepted at edge T+BL+1.
- READ:
  - Preamble: after edge T+CL-1, DQS_OE=1 and DQS_OUT=0.
  - After edge T+CL+i, DQ_OUT holds word i, DQ_OE=1, and DQS_OUT=1 for even i and 0 for odd i.
  - After edge T+CL+BL, DQ_OE=0, DQS_OE=0, DQS_OUT=0 and DQ_OUT=0.
  - The earliest next READ/WRITE is accepted at edge T+CL+BL.
- A read of a word written by an earlier, completed burst returns the new data. Bursts never overlap, so there is no same-cycle hazard.
- Asynchronous RST in mid-burst forces the reset values immediately. Partially written words remain as already stored.

## Test plan
- Mode and write/read:
  - Stimulus: LOAD MODE 0x021, ACTIVE bank1 row3, WRITE col4 with 0xA5A5 then 0x5A5A, then READ col4.
  - Required: DQ_OUT is 0xA5A5 after edge T+2 and 0x5A5A after edge T+3; DQS_OUT is 1 then 0; DQ_OE is high for exactly 2 cycles.
- Burst wrap:
  - Stimulus: BL=4 (mode 0x022), write 1,2,3,4 at col4, then READ col6.
  - Required: the read returns 3,4,1,2.
- Byte mask:
  - Stimulus: write 0xFFFF to a column, then rewrite it with 0x1234 and DM=10.
  - Required: the read returns 0xFF34.
- Closed-bank access:
  - Stimulus: READ to bank2 with no ACTIVE.
  - Required: ERR[0]=1 and DQ_OE never rises. After PRECHARGE with ADDR[10]=1, a READ to the previously open bank1 also sets ERR[0].
- Busy collision and errors:
  - Stimulus: a READ at T followed by a WRITE at T+1 (CL=3, BL=2).
  - Required: the WRITE is dropped and ERR[2]=1. A double ACTIVE sets ERR[1]. A READ before LOAD MODE sets ERR[3] and returns data at CL=3.
- Reset:
  - Stimulus: assert RST in the middle of a read burst.
  - Required: DQ_OE, DQS_OE and ERR go low in the same cycle without waiting for a clock edge; MODE_VALID=0; a following READ sets ERR[0].
